flash_boot_copier: RTL and testbench

Initiator for the flash memory word port. On `start` it reads a block of 32-bit words from flash and writes each one into the instruction RAM write port. It keeps a running checksum and flags a timeout error. It sits between the flash responder and the I-RAM, and is used at boot and for firmware reloads.

---
 rtl/flash_pkg.sv | 30 +++
 rtl/flash_boot_copier.sv | 161 ++++++++++++++++
 tb/tb_flash_boot_copier.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared types and constants for the flash boot copier.
package flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } copier_state_t;

    localparam int FLASH_BYTES = 16384;
    localparam int WORD_BYTES  = 4;
    localparam int FLASH_WORDS = 4096;
    // Width of a byte offset inside the flash window.
    localparam int WIN_W       = $clog2(FLASH_BYTES);

    // Limit a requested word count to the largest copy the window allows.
    function automatic logic [12:0] clamp_count(input logic [12:0] wc, input int max_words);
        logic [12:0] result;
        if (int'({19'b0, wc}) > max_words) begin
            result = 13'(max_words);
        end else begin
            result = wc;
        end
        return result;
    endfunction

endpackage

// File: rtl/flash_boot_copier.sv
// Copies a block of words from the flash word port into the instruction RAM,
// accumulating a checksum and aborting with an error if flash stops answering.
module flash_boot_copier
    import flash_pkg::*;
#(
    parameter logic [31:0] SRC_BASE  = 32'h0000_0000,
    parameter logic [31:0] DST_BASE  = 32'h0000_0000,
    parameter int          MAX_WORDS = FLASH_WORDS,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [12:0] word_count,
    output logic [31:0] flash_address,
    output logic [31:0] flash_data_in,
    output logic        flash_write_enable,
    input  logic [31:0] flash_data_out,
    input  logic        flash_ready,
    output logic [31:0] ram_address,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] checksum,
    output logic [12:0] words_copied
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    copier_state_t     state_q, state_d;
    logic [12:0]       n_q, n_d;
    logic [WIN_W-1:0]  src_off_q, src_off_d;
    logic [31:0]       dst_q, dst_d;
    logic [31:0]       flash_addr_q, flash_addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       checksum_q, checksum_d;
    logic [12:0]       words_q, words_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              start_ok;
    logic [12:0]       n_new;
    logic [12:0]       words_inc;
    logic [WIN_W-1:0]  src_off_inc;
    logic [WAIT_W-1:0] wait_inc;

    // The source address wraps inside the flash window; the upper base bits are kept.
    function automatic logic [31:0] src_addr(input logic [WIN_W-1:0] off);
        logic [WIN_W-1:0] low;
        low = SRC_BASE[WIN_W-1:0] + off;
        return {SRC_BASE[31:WIN_W], low};
    endfunction

    assign start_ok    = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign n_new       = clamp_count(word_count, MAX_WORDS);
    assign words_inc   = words_q + 13'd1;
    assign src_off_inc = src_off_q + WIN_W'(WORD_BYTES);
    assign wait_inc    = wait_q + WAIT_W'(1);

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            src_off_q    <= '0;
            dst_q        <= '0;
            flash_addr_q <= '0;
            wdata_q      <= '0;
            checksum_q   <= '0;
            words_q      <= '0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            src_off_q    <= src_off_d;
            dst_q        <= dst_d;
            flash_addr_q <= flash_addr_d;
            wdata_q      <= wdata_d;
            checksum_q   <= checksum_d;
            words_q      <= words_d;
            wait_q       <= wait_d;
        end
    end

    // Next-state and datapath updates for the copy sequence.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        src_off_d    = src_off_q;
        dst_d        = dst_q;
        flash_addr_d = flash_addr_q;
        wdata_d      = wdata_q;
        checksum_d   = checksum_q;
        words_d      = words_q;
        wait_d       = wait_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_ok) begin
                    n_d        = n_new;
                    checksum_d = '0;
                    words_d    = '0;
                    src_off_d  = '0;
                    dst_d      = DST_BASE;
                    if (n_new == 13'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d      = ST_ISSUE;
                        flash_addr_d = src_addr('0);
                    end
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wait_d  = '0;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (flash_ready) begin
                    wdata_d = flash_data_out;
                    state_d = ST_WRITE;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_W'(TIMEOUT)) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_WRITE: begin
                checksum_d = checksum_q + wdata_q;
                words_d    = words_inc;
                src_off_d  = src_off_inc;
                dst_d      = dst_q + 32'(WORD_BYTES);
                if (words_inc == n_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d      = ST_ISSUE;
                    flash_addr_d = src_addr(src_off_inc);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign flash_address      = flash_addr_q;
    assign flash_data_in      = 32'h0;
    assign flash_write_enable = 1'b0;
    assign ram_address        = dst_q;
    assign ram_wdata          = wdata_q;
    assign ram_we             = (state_q == ST_WRITE);
    assign busy               = (state_q == ST_ISSUE) || (state_q == ST_CAPTURE) || (state_q == ST_WRITE);
    assign done               = (state_q == ST_DONE);
    assign error              = (state_q == ST_ERR);
    assign checksum           = checksum_q;
    assign words_copied       = words_q;

endmodule

// File: tb/tb_flash_boot_copier.sv
// Directed bench for flash_boot_copier: table of copy runs plus reset and error sequences.
module tb_flash_boot_copier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] word_count;
    logic [31:0] flash_address;
    logic [31:0] flash_data_in;
    logic        flash_write_enable;
    logic [31:0] flash_data_out;
    logic        flash_ready;
    logic [31:0] ram_address;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;
    logic [12:0] words_copied;

    int total = 0;
    int bad   = 0;

    flash_boot_copier #(
        .SRC_BASE (32'h0000_3FF8),
        .DST_BASE (32'h0000_0100),
        .MAX_WORDS(4096),
        .TIMEOUT  (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .word_count        (word_count),
        .flash_address     (flash_address),
        .flash_data_in     (flash_data_in),
        .flash_write_enable(flash_write_enable),
        .flash_data_out    (flash_data_out),
        .flash_ready       (flash_ready),
        .ram_address       (ram_address),
        .ram_wdata         (ram_wdata),
        .ram_we            (ram_we),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .checksum          (checksum),
        .words_copied      (words_copied)
    );

    always #5 clk = ~clk;

    // Flash responder: word j of the copy (starting at byte 0x3FF8) holds j+1.
    logic [31:0] fmem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) fmem[(4094 + i) % 4096] = 32'(i + 1);
    end
    always @(posedge clk) flash_data_out <= fmem[flash_address[13:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          wc;
        int          stall;
        int          restart_at;
        int          exp_writes;
        int          exp_end;
        int          exp_busy;
        logic [31:0] exp_cs;
        int          exp_words;
        bit          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic apply(input int idx, input vec_t v);
        int cyc;
        int nw;
        int nbusy;
        int end_cyc;
        bit ended;
        nw = 0; nbusy = 0; end_cyc = -1; ended = 0;
        start = 1'b1;
        word_count = 13'(v.wc);
        flash_ready = 1'b1;
        @(negedge clk);
        cyc = 1;
        start = 1'b0;
        chk("start_clears_err", 32'(error), 32'd0);
        while (!ended && cyc < 13000) begin
            if (busy) nbusy++;
            if (ram_we) begin
                chk("we_cycle", 32'(cyc), 32'(3 * nw + 3 + v.stall));
                chk("ram_addr", ram_address, 32'h100 + 32'(4 * nw));
                chk("ram_data", ram_wdata, 32'(nw + 1));
                chk("flash_addr", flash_address, (32'h3FF8 + 32'(4 * nw)) & 32'h3FFF);
                nw++;
            end
            if (done || error) begin
                end_cyc = cyc;
                ended = 1'b1;
            end else begin
                flash_ready = (cyc >= 2 && cyc < 2 + v.stall) ? 1'b0 : 1'b1;
                start = (cyc == v.restart_at);
                word_count = start ? 13'd1 : 13'(v.wc);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        flash_ready = 1'b1;
        chk("run_ended", 32'(ended), 32'd1);
        chk("end_cycle", 32'(end_cyc), 32'(v.exp_end));
        chk("done_flag", 32'(done), 32'(!v.exp_err));
        chk("error_flag", 32'(error), 32'(v.exp_err));
        chk("write_count", 32'(nw), 32'(v.exp_writes));
        chk("busy_cycles", 32'(nbusy), 32'(v.exp_busy));
        chk("checksum", checksum, v.exp_cs);
        chk("words_copied", 32'(words_copied), 32'(v.exp_words));
        chk("flash_we_zero", {flash_data_in[30:0], flash_write_enable}, 32'd0);
        $display("vec %0d: wc=%0d stall=%0d end=%0d writes=%0d cs=%0d", idx, v.wc, v.stall, end_cyc, nw, checksum);
        if (v.exp_err) begin
            for (int h = 0; h < 4; h++) begin
                @(negedge clk);
                chk("err_hold", {28'd0, error, busy, done, ram_we}, 32'h8);
            end
        end
    endtask

    initial begin
        int wr_after;
        vecs[0] = '{4,    0,  0, 4,    13,    12,    32'd10,      4,    1'b0};
        vecs[1] = '{2,    5,  0, 2,    12,    11,    32'd3,       2,    1'b0};
        vecs[2] = '{0,    0,  0, 0,    1,     0,     32'd0,       0,    1'b0};
        vecs[3] = '{1,    15, 0, 1,    19,    18,    32'd1,       1,    1'b0};
        vecs[4] = '{4,    16, 0, 0,    18,    17,    32'd0,       0,    1'b1};
        vecs[5] = '{4,    0,  4, 4,    13,    12,    32'd10,      4,    1'b0};
        vecs[6] = '{5000, 0,  0, 4096, 12289, 12288, 32'd8390656, 4096, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        word_count = '0;
        flash_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_flash_addr", flash_address, 32'd0);
        chk("rst_ram_addr", ram_address, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_flags", {26'd0, ram_we, busy, done, error, flash_write_enable, 1'b0}, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        chk("rst_words", 32'(words_copied), 32'd0);
        $display("reset: outputs sampled");

        for (int i = 0; i < 7; i++) apply(i, vecs[i]);

        // Reset in the middle of a copy: write at cycle 6, reset sampled at edge 7.
        start = 1'b1;
        word_count = 13'd4;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 6; c++) @(negedge clk);
        chk("pre_rst_we", 32'(ram_we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_flash_addr", flash_address, 32'd0);
        chk("midrst_ram_addr", ram_address, 32'd0);
        chk("midrst_ram_wdata", ram_wdata, 32'd0);
        chk("midrst_flags", {27'd0, ram_we, busy, done, error, 1'b0}, 32'd0);
        chk("midrst_checksum", checksum, 32'd0);
        chk("midrst_words", 32'(words_copied), 32'd0);
        wr_after = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ram_we || done) wr_after++;
        end
        chk("post_rst_activity", 32'(wr_after), 32'd0);
        $display("reset mid-copy: activity after reset=%0d", wr_after);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
